// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse front end: receiver states,
// byte-0 field positions and the axis clamp used by the position integrator.
package mouse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_MID   = 2;
    localparam int B0_SYNC  = 3;
    localparam int B0_XS    = 4;
    localparam int B0_YS    = 5;
    localparam int B0_XO    = 6;
    localparam int B0_YO    = 7;

    localparam int FRAME_BITS = 11;

    // Sign bit set means the move ran past zero; otherwise saturate at the axis maximum.
    function automatic logic [9:0] clamp_axis(input logic [11:0] val, input logic [9:0] maxVal);
        if (val[11]) begin
            return '0;
        end else if (val > {2'b00, maxVal}) begin
            return maxVal;
        end else begin
            return val[9:0];
        end
    endfunction

endpackage

// File: rtl/mouse_tracker_ps2_rx.sv
// PS/2 byte receiver: synchronises the raw lines, detects falling clock edges
// and frames start/8 data/odd parity/stop, aborting stalled frames on timeout.
module ps2_rx
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_out_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int CntW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DataBits = FRAME_BITS - 3;

    logic [1:0]      clkSync_q;
    logic [1:0]      dataSync_q;
    logic            clkPrev_q;
    rx_state_e       state_q;
    logic [2:0]      bitCnt_q;
    logic [7:0]      shift_q;
    logic            parityOk_q;
    logic [CntW-1:0] timeout_q;
    logic            fall;
    logic            bitIn;

    // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    assign fall  = clkPrev_q & ~clkSync_q[1];
    assign bitIn = dataSync_q[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            bitCnt_q      <= '0;
            shift_q       <= '0;
            parityOk_q    <= 1'b0;
            timeout_q     <= '0;
            byte_out_o    <= '0;
            byte_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
        end else begin
            byte_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
            if (fall || state_q == IDLE) begin
                timeout_q <= '0;
            end else begin
                timeout_q <= timeout_q + CntW'(1);
            end
            if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!bitIn) begin
                            state_q  <= DATA;
                            bitCnt_q <= '0;
                        end else begin
                            frame_error_o <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q  <= {bitIn, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'(DataBits - 1)) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parityOk_q <= ^{shift_q, bitIn};
                        state_q    <= STOP;
                    end
                    default: begin
                        if (bitIn && parityOk_q) begin
                            byte_out_o   <= shift_q;
                            byte_valid_o <= 1'b1;
                        end else begin
                            frame_error_o <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                endcase
            end else if (state_q != IDLE && timeout_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                frame_error_o <= 1'b1;
                state_q       <= IDLE;
            end
        end
    end

endmodule

// File: rtl/mouse_tracker.sv
// Assembles 3-byte PS/2 movement packets and integrates their deltas into a
// screen-clamped absolute cursor position with button state.
module mouse_tracker
    import mouse_pkg::*;
#(
    parameter logic [9:0] X_MAX          = 10'd639,
    parameter logic [9:0] Y_MAX          = 10'd479,
    parameter logic [9:0] X_INIT         = 10'd320,
    parameter logic [9:0] Y_INIT         = 10'd240,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [9:0] mouse_x_o,
    output logic [9:0] mouse_y_o,
    output logic [2:0] buttons_o,
    output logic       packet_valid_o,
    output logic       frame_error_o
);

    logic [7:0]  rxByte;
    logic        rxValid;
    logic        rxError;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [2:0]  buttons_q, buttons_d;
    logic        packetValid_q, packetValid_d;
    logic [11:0] nx;
    logic [11:0] ny;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_out_o   (rxByte),
        .byte_valid_o (rxValid),
        .frame_error_o(rxError)
    );

    // Screen y grows downward while PS/2 y grows upward, hence the subtraction.
    assign nx = {2'b00, x_q} + {{4{byte0_q[B0_XS]}}, byte1_q};
    assign ny = {2'b00, y_q} - {{4{byte0_q[B0_YS]}}, rxByte};

    always_comb begin
        idx_d         = idx_q;
        byte0_d       = byte0_q;
        byte1_d       = byte1_q;
        x_d           = x_q;
        y_d           = y_q;
        buttons_d     = buttons_q;
        packetValid_d = 1'b0;
        if (rxError) begin
            idx_d = 2'd0;
        end else if (rxValid) begin
            case (idx_q)
                2'd0: begin
                    if (rxByte[B0_SYNC]) begin
                        byte0_d = rxByte;
                        idx_d   = 2'd1;
                    end
                end
                2'd1: begin
                    byte1_d = rxByte;
                    idx_d   = 2'd2;
                end
                default: begin
                    idx_d         = 2'd0;
                    packetValid_d = 1'b1;
                    buttons_d     = {byte0_q[B0_MID], byte0_q[B0_RIGHT], byte0_q[B0_LEFT]};
                    if (!byte0_q[B0_XO]) begin
                        x_d = clamp_axis(nx, X_MAX);
                    end
                    if (!byte0_q[B0_YO]) begin
                        y_d = clamp_axis(ny, Y_MAX);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q         <= 2'd0;
            byte0_q       <= '0;
            byte1_q       <= '0;
            x_q           <= X_INIT;
            y_q           <= Y_INIT;
            buttons_q     <= '0;
            packetValid_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            byte0_q       <= byte0_d;
            byte1_q       <= byte1_d;
            x_q           <= x_d;
            y_q           <= y_d;
            buttons_q     <= buttons_d;
            packetValid_q <= packetValid_d;
        end
    end

    assign mouse_x_o      = x_q;
    assign mouse_y_o      = y_q;
    assign buttons_o      = buttons_q;
    assign packet_valid_o = packetValid_q;
    assign frame_error_o  = rxError;

endmodule

// File: tb/tb_mouse_tracker.sv
// Drives PS/2 frames into mouse_tracker and checks it every cycle against a
// packet-level cursor model, with directed scenarios followed by random packets.
module tb_mouse_tracker;

    localparam int HALF    = 5;
    localparam int TIMEOUT = 50000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2Clk;
    logic       ps2Data;
    logic [9:0] mouseX;
    logic [9:0] mouseY;
    logic [2:0] buttons;
    logic       packetValid;
    logic       frameError;

    mouse_tracker dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ps2_clk_i     (ps2Clk),
        .ps2_data_i    (ps2Data),
        .mouse_x_o     (mouseX),
        .mouse_y_o     (mouseY),
        .buttons_o     (buttons),
        .packet_valid_o(packetValid),
        .frame_error_o (frameError)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] btn;
    } pkt_t;

    int         checks = 0;
    int         errors = 0;
    int         modelX, modelY, modelIdx;
    logic [2:0] modelBtn;
    logic [7:0] modelB0, modelB1;
    int         expErrors = 0, expPackets = 0;
    int         obsErrors = 0, obsPackets = 0;
    pkt_t       expQ[$];
    int         curX = 320, curY = 240;
    logic [2:0] curBtn = 3'b000;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int clampTo(input int v, input int maxV);
        if (v < 0) return 0;
        if (v > maxV) return maxV;
        return v;
    endfunction

    // Packet-level model: what a correct tracker does with each delivered byte.
    task automatic modelByte(input logic [7:0] b, input bit good);
        int dx, dy;
        if (!good) begin
            expErrors++;
            modelIdx = 0;
            return;
        end
        if (modelIdx == 0) begin
            if (b[3]) begin
                modelB0  = b;
                modelIdx = 1;
            end
        end else if (modelIdx == 1) begin
            modelB1  = b;
            modelIdx = 2;
        end else begin
            dx = modelB0[4] ? int'(modelB1) - 256 : int'(modelB1);
            dy = modelB0[5] ? int'(b) - 256 : int'(b);
            if (!modelB0[6]) modelX = clampTo(modelX + dx, 639);
            if (!modelB0[7]) modelY = clampTo(modelY - dy, 479);
            modelBtn = modelB0[2:0];
            expQ.push_back('{modelX, modelY, modelBtn});
            expPackets++;
            modelIdx = 0;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2Bit(input logic b);
        ps2Data = b;
        waitCycles(HALF);
        ps2Clk = 1'b0;
        waitCycles(HALF);
        ps2Clk = 1'b1;
    endtask

    // The model is updated first because the DUT may report before the frame task returns.
    task automatic applyStimulus(input logic [7:0] b, input bit badParity);
        logic p;
        modelByte(b, !badParity);
        p = ~(^b) ^ badParity;
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(b[i]);
        ps2Bit(p);
        ps2Bit(1'b1);
        ps2Data = 1'b1;
        waitCycles(2 * HALF);
    endtask

    task automatic sendPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        applyStimulus(b0, 1'b0);
        applyStimulus(b1, 1'b0);
        applyStimulus(b2, 1'b0);
    endtask

    task automatic doReset();
        reset    = 1'b1;
        modelX   = 320;
        modelY   = 240;
        modelBtn = 3'b000;
        modelIdx = 0;
        expQ.delete();
        waitCycles(3);
        reset = 1'b0;
        waitCycles(1);
    endtask

    task automatic checkPos(input string name, input int x, input int y, input int btn);
        waitCycles(10);
        checkOutput({name, "_x"}, int'(mouseX), x);
        checkOutput({name, "_y"}, int'(mouseY), y);
        checkOutput({name, "_btn"}, int'(buttons), btn);
        checkOutput({name, "_model_x"}, modelX, x);
        checkOutput({name, "_model_y"}, modelY, y);
    endtask

    task automatic checkCounts(input string name);
        waitCycles(10);
        checkOutput({name, "_errors"}, obsErrors, expErrors);
        checkOutput({name, "_packets"}, obsPackets, expPackets);
        checkOutput({name, "_pending"}, expQ.size(), 0);
    endtask

    // Every cycle out of reset, outputs must equal the last packet the model released.
    always @(negedge clk) begin
        pkt_t p;
        if (reset) begin
            curX   = 320;
            curY   = 240;
            curBtn = 3'b000;
        end else begin
            if (frameError) obsErrors++;
            checks++;
            if (packetValid && frameError) begin
                errors++;
                $display("[TB] FAIL pv_fe_overlap: both asserted, required exclusive");
            end
            if (packetValid) begin
                obsPackets++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_packet: packet_valid=1, required 0");
                end else begin
                    p      = expQ.pop_front();
                    curX   = p.x;
                    curY   = p.y;
                    curBtn = p.btn;
                end
            end
            checkOutput("cyc_x", int'(mouseX), curX);
            checkOutput("cyc_y", int'(mouseY), curY);
            checkOutput("cyc_btn", int'(buttons), int'(curBtn));
        end
    end

    initial begin
        logic [7:0] b0, b1, b2;
        reset   = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        doReset();
        checkOutput("reset_x", int'(mouseX), 320);
        checkOutput("reset_y", int'(mouseY), 240);
        checkOutput("reset_btn", int'(buttons), 0);
        checkOutput("reset_pv", int'(packetValid), 0);
        checkOutput("reset_fe", int'(frameError), 0);

        sendPacket(8'h08, 8'h0A, 8'h00);
        checkPos("move_right", 330, 240, 0);
        sendPacket(8'h29, 8'h00, 8'hF6);
        checkPos("move_down", 330, 250, 1);

        sendPacket(8'h08, 8'hFF, 8'h00);
        sendPacket(8'h08, 8'h2D, 8'h00);
        checkPos("at_630", 630, 250, 0);
        sendPacket(8'h08, 8'h14, 8'h00);
        checkPos("clamp_max", 639, 250, 0);
        sendPacket(8'h18, 8'h00, 8'h00);
        sendPacket(8'h18, 8'h00, 8'h00);
        sendPacket(8'h18, 8'h95, 8'h00);
        checkPos("at_20", 20, 250, 0);
        sendPacket(8'h18, 8'hCE, 8'h00);
        checkPos("clamp_zero", 0, 250, 0);
        sendPacket(8'h48, 8'h7F, 8'h00);
        checkPos("x_overflow", 0, 250, 0);
        checkCounts("clamp");

        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h01, 1'b1);
        sendPacket(8'h08, 8'h01, 8'h00);
        checkPos("after_parity", 1, 250, 0);
        checkCounts("parity");

        applyStimulus(8'h00, 1'b0);
        sendPacket(8'h08, 8'h05, 8'h00);
        checkPos("resync", 6, 250, 0);

        expErrors++;
        modelIdx = 0;
        ps2Bit(1'b0);
        for (int i = 0; i < 3; i++) ps2Bit(1'b1);
        waitCycles(TIMEOUT + 20);
        checkCounts("timeout");
        sendPacket(8'h08, 8'h01, 8'h00);
        checkPos("after_timeout", 7, 250, 0);

        applyStimulus(8'h09, 1'b0);
        applyStimulus(8'h01, 1'b0);
        doReset();
        checkOutput("midreset_x", int'(mouseX), 320);
        checkOutput("midreset_y", int'(mouseY), 240);
        checkOutput("midreset_btn", int'(buttons), 0);
        applyStimulus(8'h00, 1'b0);
        sendPacket(8'h08, 8'h02, 8'h00);
        checkPos("after_reset", 322, 240, 0);
        checkCounts("directed");

        for (int n = 0; n < 30; n++) begin
            b0    = 8'($urandom);
            b0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) applyStimulus(8'($urandom) & 8'hF7, 1'b0);
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(b0, 1'b0);
                applyStimulus(b1, 1'b1);
            end else begin
                sendPacket(b0, b1, b2);
            end
        end
        checkCounts("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_tracker.md
# mouse_tracker

Upstream input stage for the rope simulator. It receives the PS/2 mouse serial stream and decodes standard 3-byte movement packets. It integrates the signed deltas into an absolute, screen-clamped cursor position that drives the rope's `in_mouse_x`/`in_mouse_y` (10-bit integer pixel coordinates; the rope widens them to Q10.12 internally). The block also exports button state and per-packet strobes for debug and UI use.

## Interface
- `X_MAX`, 639: maximum cursor x, inclusive.
- `Y_MAX`, 479: maximum cursor y, inclusive.
- `X_INIT`, 320: cursor x after reset.
- `Y_INIT`, 240: cursor y after reset.
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles mid-frame before the receiver aborts the frame (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, with `reset` synchronous and active-high.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `mouse_x`  out  10  cursor x, range 0..X_MAX; connects to `in_mouse_x`.
- `mouse_y`  out  10  cursor y, range 0..Y_MAX, downward-positive; connects to `in_mouse_y`.
- `buttons`  out  3  {middle, right, left} from the last valid packet.
- `packet_valid`  out  1  one-cycle pulse, coincident with updated `mouse_x`/`mouse_y`/`buttons`.
- `frame_error`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - A falling edge is a synchronised clock change from 1 to 0 between consecutive cycles.
  - Data is sampled on the same cycle the falling edge is detected.
- Receiver FSM (`IDLE`, `DATA`, `PARITY`, `STOP`):
  - `IDLE`: an edge with data 0 (start bit) moves to `DATA` with a bit count of 0. An edge with data 1 raises `frame_error` and stays in `IDLE`.
  - `DATA`: shifts in 8 bits, LSB first, then moves to `PARITY`.
  - `PARITY`: checks odd parity over the 8 data bits plus the parity bit.
  - `STOP`: data must be 1. If parity and stop are both good, the byte is emitted as a one-cycle `byte_valid` and the FSM returns to `IDLE`. Otherwise `frame_error` pulses, no byte is emitted, and the FSM returns to `IDLE`.
  - Timeout: the counter resets on every falling edge. If it reaches TIMEOUT_CYCLES in any state other than `IDLE`, `frame_error` pulses and the FSM returns to `IDLE`.
- Packet assembler (byte index 0..2):
  - Index 0 accepts a byte only if bit3 = 1. A byte with bit3 = 0 is dropped (resynchronisation) and does not raise `frame_error`.
  - Any `frame_error` resets the index to 0 and discards the partial packet.
- Byte 0 fields:
  - bit0 left, bit1 right, bit2 middle.
  - bit4 X sign, bit5 Y sign.
  - bit6 X overflow, bit7 Y overflow.
- Deltas:
  - dx = {Xsign, byte1} and dy = {Ysign, byte2}, each 9-bit two's complement (-256..255).
- Position update, on acceptance of byte 2:
  - Compute in 12-bit signed: nx = x + dx and ny = y − dy (PS/2 Y is upward-positive).
  - If the axis overflow bit is set, that axis keeps its old value.
  - Clamp: a negative result becomes 0; a result above the axis maximum becomes that maximum.
  - `buttons` always update from byte 0.

## Timing
- Reset values:
  - `mouse_x` = X_INIT, `mouse_y` = Y_INIT.
  - `buttons` = 0, `packet_valid` = 0, `frame_error` = 0.
  - Receiver in `IDLE`, byte index 0, timeout counter 0.
- Reset has priority over every concurrent event. Reset mid-frame or mid-packet discards all partial data.
- Latency:
  - A raw `ps2_clk` fall is detected 3 `clk` cycles later (2 synchroniser stages plus edge register).
  - `byte_valid` is asserted the cycle after the stop-bit edge is detected.
  - Outputs update, and `packet_valid` pulses, one cycle after `byte_valid` of byte 2.
- `frame_error` and `packet_valid` are never asserted in the same cycle.
- Outputs hold their value between packets.

## Structure
- Package `mouse_pkg` holds:
  - receiver state enum;
  - byte-0 bit-position constants (`B0_LEFT`, `B0_RIGHT`, `B0_MID`, `B0_SYNC`, `B0_XS`, `B0_YS`, `B0_XO`, `B0_YO`);
  - frame length constant (11).
- Sub-module `ps2_rx` contains the synchronisers, edge detect, receiver FSM and timeout. Its outputs are `byte_out[7:0]`, `byte_valid` and `frame_error`.
- `mouse_tracker` instantiates `ps2_rx` and implements the packet assembler, integration and clamping.

## Test plan
- Movement right: after reset, send 0x08, 0x0A, 0x00 → `packet_valid` pulse; `mouse_x`=330, `mouse_y`=240, `buttons`=0.
- Movement down with left button: send 0x29, 0x00, 0xF6 (dy = −10) → `mouse_y`=250, `mouse_x` unchanged, `buttons`=3'b001.
- Clamping, x at 630:
  - Send 0x08, 0x14, 0x00 → `mouse_x`=639.
  - Then from x = 20, send 0x18, 0xCE, 0x00 (dx = −50) → `mouse_x`=0.
  - With X overflow set, send 0x48, 0x7F, 0x00 → x unchanged.
- Parity error in byte 1 → `frame_error` pulse, no `packet_valid`. A following clean packet 0x08, 0x01, 0x00 updates x by +1.
- Resynchronisation and timeout:
  - A leading byte 0x00 is dropped silently; the next 0x08, 0x05, 0x00 gives x +5.
  - Stopping `ps2_clk` after 4 bits for TIMEOUT_CYCLES → `frame_error`. The next frame decodes correctly.
- Asserting `reset` mid-packet (after byte 1) → outputs return to 320/240/0. The bytes remaining from the interrupted packet are dropped as expected (bit3 = 0) or misframed, with no spurious update.
